alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the 8-bit CPU ALU.
- Operand width W and register count NREG are generic.
- Opcodes are encoded, not one-hot strobes. A start/busy/done handshake replaces per-op strobes.
- MUL (shift-add) and DIV (restoring) are iterative. All other ops complete in one cycle.
- Sits between the register file and the control unit; the control unit waits on done.

Parameters:
- W, 8, operand/result width (≥4).
- NREG, 4, number of data registers presented on dr_flat.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ealu  in  1  ALU enable; start is ignored when low.
- start  in  1  request; accepted when ealu && start && !busy.
- op  in  5  opcode: 0 ADD, 1 SUB, 2 ADC, 3 SBB, 4 MUL, 5 DIV, 6 INC, 7 DEC, 8 SHL, 9 SHR, 10 NOT, 11 NEG, 12 AND, 13 OR, 16 JMP, 17 JA, 18 JB, 19 JE; others reserved.
- tgt1  in  NREG  one-hot select of operand A.
- tgt2  in  NREG  one-hot select of operand B.
- dr_flat  in  NREG*W  registers; DRi = dr_flat[i*W +: W].
- flags_in  in  8  current flags: bit0 CF, bit1 ZF, bit2 SF, bit3 OF, bit4 DZ, bits7:5 reserved.
- busy  out  1  iterative op in progress.
- done  out  1  one-cycle completion pulse.
- dout  out  W  result / product low half / quotient.
- dout_hi  out  W  product high half / remainder; 0 for other ops.
- flags_out  out  8  updated flags.
- jmp  out  1  jump-taken.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): busy, done, dout, dout_hi, flags_out, jmp = 0; FSM→IDLE. Reset mid-iteration discards the op and no done pulse follows. rst has priority over start.
- Operand select: lowest set bit of tgt wins; all-zero selects DR0.
- A, B, flags_in and op are captured at the accept edge. Later input changes do not affect the in-flight op.
- FSM states:
  - IDLE: accept of a single-cycle op → results registered at that edge, done=1 the following cycle, stay IDLE.
  - IDLE: accept of MUL/DIV with B≠0 → ITER, busy=1, count=W.
  - ITER: one step per cycle; on the W-th step register results, busy=0, done=1, → IDLE. Latency from accept edge to done = W+1 cycles.
  - DIV with B=0: single-cycle; dout=all-ones, dout_hi=A, DZ=1.
- done is high exactly one cycle. start in the done cycle is accepted (back-to-back). start while busy is ignored, with no queueing.
- Outputs hold their last values between completions.
- Arithmetic is modulo 2^W:
  - ADD/ADC: A+B(+CF); CF=carry, OF=signed overflow.
  - SUB/SBB: A−B(−CF); CF=borrow.
  - INC/DEC: CF unchanged; OF as signed overflow.
  - NEG: 0−A; CF=(A≠0).
  - NOT/AND/OR: CF=OF=0.
  - SHL/SHR: logical shift of A by B.
    - B=0 leaves result=A and CF unchanged.
    - B≥W gives result 0 and CF=0.
    - Otherwise CF = last bit shifted out.
  - MUL: unsigned 2W-bit product {dout_hi,dout}; CF=OF=(dout_hi≠0); ZF on the full product; SF=dout_hi msb.
  - DIV: unsigned; dout=quotient, dout_hi=remainder; CF=OF=0.
- Common flag rules:
  - ZF and SF are computed on dout for all result ops except MUL.
  - DZ is cleared by every op except DIV-by-zero.
  - bits7:5 pass through from flags_in.
- Jumps: dout and dout_hi hold; flags_out = captured flags_in.
  - JMP → jmp=1.
  - JA → jmp=!CF&&!ZF.
  - JB → jmp=CF.
  - JE → jmp=ZF.
  - jmp=0 after any non-jump completion.
- Reserved op: single-cycle; dout=dout_hi=0, flags_out=flags_in, jmp=0.

Test Plan (W=8, NREG=4, DR0=0x20, DR1=0x21, DR2=0x22, DR3=0x23, flags_in=0x01):
- ADD tgt1=0001, tgt2=1000 → 1 cycle later done=1, dout=0x43, flags_out=0x00. ADC on the same operands → dout=0x44.
- SUB DR0−DR3 → dout=0xFD, CF=1, SF=1, ZF=0. NEG DR0 → dout=0xE0, CF=1.
- MUL DR0×DR3:
  - busy=1 for 8 cycles, done exactly 9 cycles after accept.
  - Result: dout=0x60, dout_hi=0x04, CF=OF=1.
  - A start pulse mid-op is ignored.
- DIV DR3/DR0 → dout=0x01, dout_hi=0x03 after 9 cycles. With DR0 set to 0x00 → 1-cycle done, dout=0xFF, dout_hi=0x23, DZ=1.
- SHL DR0 by DR3=0x01 → dout=0x40, CF=0. SHR by B=0x09 → dout=0x00, CF=0. Back-to-back start in the done cycle yields consecutive done pulses.
- JA with flags_in=0x01 → jmp=0. JMP → jmp=1. Assert rst 4 cycles into a MUL → all outputs 0, no done pulse, next ADD completes normally.

Source files
------------

// File: rtl/alu_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_iter_if                                                     |
// | Purpose  : Control-unit <-> iterative ALU bundle (request, operands, flags |
// |            and completion/result signals).                                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface alu_iter_if #(
    parameter int W    = 8,
    parameter int NREG = 4
);
    logic              ealu;
    logic              start;
    logic [4:0]        op;
    logic [NREG-1:0]   tgt1;
    logic [NREG-1:0]   tgt2;
    logic [NREG*W-1:0] dr_flat;
    logic [7:0]        flags_in;
    logic              busy;
    logic              done;
    logic [W-1:0]      dout;
    logic [W-1:0]      dout_hi;
    logic [7:0]        flags_out;
    logic              jmp;

    modport master (
        output ealu, start, op, tgt1, tgt2, dr_flat, flags_in,
        input  busy, done, dout, dout_hi, flags_out, jmp
    );

    modport slave (
        input  ealu, start, op, tgt1, tgt2, dr_flat, flags_in,
        output busy, done, dout, dout_hi, flags_out, jmp
    );
endinterface
`default_nettype wire

// File: rtl/alu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_iter                                                        |
// | Purpose  : Multi-cycle ALU; single-cycle logic/arith ops, shift-add MUL    |
// |            and restoring DIV, with start/busy/done handshake.              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module alu_iter #(
    parameter int W    = 8,
    parameter int NREG = 4
) (
    input  logic      clk,
    input  logic      rst,
    alu_iter_if.slave bus
);

    localparam logic [4:0] c_OP_ADD = 5'd0;
    localparam logic [4:0] c_OP_SUB = 5'd1;
    localparam logic [4:0] c_OP_ADC = 5'd2;
    localparam logic [4:0] c_OP_SBB = 5'd3;
    localparam logic [4:0] c_OP_MUL = 5'd4;
    localparam logic [4:0] c_OP_DIV = 5'd5;
    localparam logic [4:0] c_OP_INC = 5'd6;
    localparam logic [4:0] c_OP_DEC = 5'd7;
    localparam logic [4:0] c_OP_SHL = 5'd8;
    localparam logic [4:0] c_OP_SHR = 5'd9;
    localparam logic [4:0] c_OP_NOT = 5'd10;
    localparam logic [4:0] c_OP_NEG = 5'd11;
    localparam logic [4:0] c_OP_AND = 5'd12;
    localparam logic [4:0] c_OP_OR  = 5'd13;
    localparam logic [4:0] c_OP_JMP = 5'd16;
    localparam logic [4:0] c_OP_JA  = 5'd17;
    localparam logic [4:0] c_OP_JB  = 5'd18;
    localparam logic [4:0] c_OP_JE  = 5'd19;

    localparam logic [1:0] c_K_RES  = 2'd0;
    localparam logic [1:0] c_K_JUMP = 2'd1;
    localparam logic [1:0] c_K_RSVD = 2'd2;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_ITER = 1'b1;

    localparam int           c_CW    = $clog2(W + 1);
    localparam logic [W-1:0] c_WIDTH = W'(W);
    localparam logic [W-1:0] c_SMAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] c_SMIN  = {1'b1, {(W-1){1'b0}}};

    logic [0:0]      r_state;
    logic            r_busy;
    logic            r_done;
    logic [W-1:0]    r_dout;
    logic [W-1:0]    r_dout_hi;
    logic [7:0]      r_flags;
    logic            r_jmp;
    logic [c_CW-1:0] r_count;
    logic            r_div;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic [2:0]      r_fl_hi;

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic         w_accept;
    logic [W:0]   w_sum;
    logic [W-1:0] w_res;
    logic [W-1:0] w_res_hi;
    logic         w_cf;
    logic         w_of;
    logic         w_dz;
    logic [1:0]   w_kind;
    logic         w_jmp;
    logic         w_iter;
    logic [7:0]   w_flags_res;

    logic [W:0]   w_madd;
    logic [W:0]   w_rsh;
    logic [W:0]   w_diff;
    logic [W-1:0] w_step_hi;
    logic [W-1:0] w_step_lo;
    logic         w_fin_cf;
    logic         w_fin_zf;
    logic         w_fin_sf;
    logic [7:0]   w_fin_flags;

    // Scanning from the top down lets the lowest set select bit win.
    always_comb begin
        w_a = bus.dr_flat[W-1:0];
        w_b = bus.dr_flat[W-1:0];
        for (int i = NREG - 1; i >= 0; i--) begin
            if (bus.tgt1[i]) w_a = bus.dr_flat[i*W +: W];
            if (bus.tgt2[i]) w_b = bus.dr_flat[i*W +: W];
        end
    end

    assign w_accept = bus.ealu && bus.start && !r_busy;

    always_comb begin
        w_sum    = '0;
        w_res    = '0;
        w_res_hi = '0;
        w_cf     = bus.flags_in[0];
        w_of     = 1'b0;
        w_dz     = 1'b0;
        w_kind   = c_K_RES;
        w_jmp    = 1'b0;
        w_iter   = 1'b0;
        case (bus.op)
            c_OP_ADD, c_OP_ADC: begin
                w_sum = {1'b0, w_a} + {1'b0, w_b}
                      + {{W{1'b0}}, (bus.op == c_OP_ADC) & bus.flags_in[0]};
                w_res = w_sum[W-1:0];
                w_cf  = w_sum[W];
                w_of  = (w_a[W-1] == w_b[W-1]) && (w_res[W-1] != w_a[W-1]);
            end
            c_OP_SUB, c_OP_SBB: begin
                w_sum = {1'b0, w_a} - {1'b0, w_b}
                      - {{W{1'b0}}, (bus.op == c_OP_SBB) & bus.flags_in[0]};
                w_res = w_sum[W-1:0];
                w_cf  = w_sum[W];
                w_of  = (w_a[W-1] != w_b[W-1]) && (w_res[W-1] != w_a[W-1]);
            end
            c_OP_INC: begin
                w_res = w_a + {{(W-1){1'b0}}, 1'b1};
                w_of  = (w_a == c_SMAX);
            end
            c_OP_DEC: begin
                w_res = w_a - {{(W-1){1'b0}}, 1'b1};
                w_of  = (w_a == c_SMIN);
            end
            c_OP_NEG: begin
                w_res = {W{1'b0}} - w_a;
                w_cf  = |w_a;
                w_of  = (w_a == c_SMIN);
            end
            c_OP_NOT: begin
                w_res = ~w_a;
                w_cf  = 1'b0;
            end
            c_OP_AND: begin
                w_res = w_a & w_b;
                w_cf  = 1'b0;
            end
            c_OP_OR: begin
                w_res = w_a | w_b;
                w_cf  = 1'b0;
            end
            // The extra bit beside A catches the last bit shifted out.
            c_OP_SHL: begin
                if (w_b == '0) begin
                    w_res = w_a;
                end else if (w_b >= c_WIDTH) begin
                    w_cf = 1'b0;
                end else begin
                    w_sum = {1'b0, w_a} << w_b;
                    w_res = w_sum[W-1:0];
                    w_cf  = w_sum[W];
                end
            end
            c_OP_SHR: begin
                if (w_b == '0) begin
                    w_res = w_a;
                end else if (w_b >= c_WIDTH) begin
                    w_cf = 1'b0;
                end else begin
                    w_sum = {w_a, 1'b0} >> w_b;
                    w_res = w_sum[W:1];
                    w_cf  = w_sum[0];
                end
            end
            c_OP_MUL: begin
                w_cf   = 1'b0;
                w_iter = (w_b != '0);
            end
            c_OP_DIV: begin
                w_cf   = 1'b0;
                w_iter = (w_b != '0);
                w_res    = '1;
                w_res_hi = w_a;
                w_dz     = 1'b1;
            end
            c_OP_JMP: begin
                w_kind = c_K_JUMP;
                w_jmp  = 1'b1;
            end
            c_OP_JA: begin
                w_kind = c_K_JUMP;
                w_jmp  = !bus.flags_in[0] && !bus.flags_in[1];
            end
            c_OP_JB: begin
                w_kind = c_K_JUMP;
                w_jmp  = bus.flags_in[0];
            end
            c_OP_JE: begin
                w_kind = c_K_JUMP;
                w_jmp  = bus.flags_in[1];
            end
            default: begin
                w_kind = c_K_RSVD;
            end
        endcase
    end

    assign w_flags_res = {bus.flags_in[7:5], w_dz, w_of, w_res[W-1], ~|w_res, w_cf};

    // One iteration: shift-add multiply (product grows into r_hi while the
    // multiplier drains out of r_lo) or restoring divide (quotient bits
    // shift into r_lo, partial remainder in r_hi).
    always_comb begin
        w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(W+1){1'b0}});
        w_rsh  = {r_hi, r_lo[W-1]};
        w_diff = w_rsh - {1'b0, r_b};
        if (r_div) begin
            w_step_hi = w_diff[W] ? w_rsh[W-1:0] : w_diff[W-1:0];
            w_step_lo = {r_lo[W-2:0], ~w_diff[W]};
        end else begin
            w_step_hi = w_madd[W:1];
            w_step_lo = {w_madd[0], r_lo[W-1:1]};
        end
    end

    always_comb begin
        if (r_div) begin
            w_fin_cf = 1'b0;
            w_fin_zf = ~|w_step_lo;
            w_fin_sf = w_step_lo[W-1];
        end else begin
            w_fin_cf = |w_step_hi;
            w_fin_zf = ~|{w_step_hi, w_step_lo};
            w_fin_sf = w_step_hi[W-1];
        end
    end

    assign w_fin_flags = {r_fl_hi, 1'b0, w_fin_cf, w_fin_sf, w_fin_zf, w_fin_cf};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dout    <= '0;
            r_dout_hi <= '0;
            r_flags   <= '0;
            r_jmp     <= 1'b0;
            r_count   <= '0;
            r_div     <= 1'b0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_fl_hi   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (w_iter) begin
                            r_state <= c_ST_ITER;
                            r_busy  <= 1'b1;
                            r_count <= c_CW'(W);
                            r_div   <= (bus.op == c_OP_DIV);
                            r_b     <= w_b;
                            r_hi    <= '0;
                            r_lo    <= w_a;
                            r_fl_hi <= bus.flags_in[7:5];
                        end else begin
                            r_done <= 1'b1;
                            case (w_kind)
                                c_K_RES: begin
                                    r_dout    <= w_res;
                                    r_dout_hi <= w_res_hi;
                                    r_flags   <= w_flags_res;
                                    r_jmp     <= 1'b0;
                                end
                                c_K_JUMP: begin
                                    r_flags <= bus.flags_in;
                                    r_jmp   <= w_jmp;
                                end
                                default: begin
                                    r_dout    <= '0;
                                    r_dout_hi <= '0;
                                    r_flags   <= bus.flags_in;
                                    r_jmp     <= 1'b0;
                                end
                            endcase
                        end
                    end
                end
                c_ST_ITER: begin
                    r_hi    <= w_step_hi;
                    r_lo    <= w_step_lo;
                    r_count <= r_count - c_CW'(1);
                    if (r_count == c_CW'(1)) begin
                        r_state   <= c_ST_IDLE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_dout    <= w_step_lo;
                        r_dout_hi <= w_step_hi;
                        r_flags   <= w_fin_flags;
                        r_jmp     <= 1'b0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.dout      = r_dout;
    assign bus.dout_hi   = r_dout_hi;
    assign bus.flags_out = r_flags;
    assign bus.jmp       = r_jmp;

endmodule
`default_nettype wire

// File: tb/tb_alu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_iter                                                     |
// | Purpose  : Directed + randomized bench for alu_iter against an arithmetic  |
// |            reference model.                                                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_alu_iter;
    localparam int W    = 8;
    localparam int NREG = 4;
    localparam int M    = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_if #(.W(W), .NREG(NREG)) bus ();
    alu_iter #(.W(W), .NREG(NREG)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_total = 0;
    int n_bad   = 0;
    int exp_dout = 0;
    int exp_hi   = 0;
    logic [W-1:0] dr [NREG];
    int valid_ops [18] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 16, 17, 18, 19};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
    endfunction

    function automatic int sel(input logic [NREG-1:0] t);
        for (int i = 0; i < NREG; i++) if (t[i]) return i;
        return 0;
    endfunction

    task automatic load_dr();
        for (int i = 0; i < NREG; i++) bus.dr_flat[i*W +: W] = dr[i];
    endtask

    // Expected result, flags (with a mask of the bits the op defines) and latency.
    task automatic model(input int op, input int a, input int b, input int fin,
                         output int r, output int hi, output int fl, output int jp,
                         output int lat, output int mask);
        int cf, zf, sf, of, dz, s, smax, smin, kind;
        longint p;
        cf = fin & 1; zf = 0; sf = 0; of = 0; dz = 0;
        smax = (1 << (W - 1)) - 1; smin = -(1 << (W - 1));
        r = 0; hi = 0; jp = 0; lat = 1; mask = 'hFF; kind = 0;
        case (op)
            0, 2: begin
                s  = a + b + ((op == 2) ? cf : 0);
                r  = s & M; cf = int'(s > M);
                s  = sx(a) + sx(b) + ((op == 2) ? (fin & 1) : 0);
                of = int'(s > smax || s < smin);
            end
            1, 3: begin
                s = a - b - ((op == 3) ? cf : 0);
                r = s & M; cf = int'(s < 0); mask = 'hF7;
            end
            6: begin r = (a + 1) & M; of = int'(sx(a) + 1 > smax); end
            7: begin r = (a - 1) & M; of = int'(sx(a) - 1 < smin); end
            8, 9: begin
                mask = 'hF7;
                if (b == 0) r = a;
                else if (b >= W) begin r = 0; cf = 0; end
                else if (op == 8) begin r = (a << b) & M; cf = (a >> (W - b)) & 1; end
                else begin r = a >> b; cf = (a >> (b - 1)) & 1; end
            end
            10: begin r = (~a) & M; cf = 0; end
            11: begin r = (-a) & M; cf = int'(a != 0); mask = 'hF7; end
            12: begin r = a & b; cf = 0; end
            13: begin r = a | b; cf = 0; end
            4: begin
                p = longint'(a) * longint'(b);
                r = int'(p & M); hi = int'(p >> W);
                cf = int'(hi != 0); of = cf; zf = int'(p == 0); sf = (hi >> (W - 1)) & 1;
                lat = (b != 0) ? W + 1 : 1; kind = 3;
            end
            5: begin
                if (b != 0) begin r = a / b; hi = a % b; cf = 0; lat = W + 1; end
                else begin r = M; hi = a; dz = 1; mask = 'hF6; end
            end
            16, 17, 18, 19: begin
                r = exp_dout; hi = exp_hi; kind = 1;
                if (op == 16) jp = 1;
                else if (op == 17) jp = int'(((fin & 1) == 0) && ((fin & 2) == 0));
                else if (op == 18) jp = fin & 1;
                else jp = (fin >> 1) & 1;
            end
            default: kind = 2;
        endcase
        if (kind == 0) begin
            zf = int'(r == 0);
            sf = (r >> (W - 1)) & 1;
        end
        if (kind == 1 || kind == 2) fl = fin;
        else fl = (fin & 'hE0) | (dz << 4) | (of << 3) | (sf << 2) | (zf << 1) | cf;
    endtask

    task automatic run_op(input int op, input logic [NREG-1:0] t1, input logic [NREG-1:0] t2,
                          input int fin, input bit poke);
        int a, b, r, hi, fl, jp, lat, mask, cyc, bcnt;
        a = int'(dr[sel(t1)]);
        b = int'(dr[sel(t2)]);
        model(op, a, b, fin, r, hi, fl, jp, lat, mask);
        @(negedge clk);
        bus.op = op[4:0]; bus.tgt1 = t1; bus.tgt2 = t2; bus.flags_in = fin[7:0];
        load_dr();
        bus.ealu = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1; bcnt = 0;
        while (bus.done !== 1'b1 && cyc <= 2 * W + 4) begin
            if (bus.busy === 1'b1) bcnt++;
            if (poke && cyc == 3) begin
                bus.start = 1'b1; bus.op = 5'd0; bus.flags_in = ~fin[7:0];
                bus.tgt1 = ~t1; bus.dr_flat = ~bus.dr_flat;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        check($sformatf("op%0d latency", op), cyc, lat);
        check($sformatf("op%0d busy_cycles", op), bcnt, lat - 1);
        check($sformatf("op%0d busy_at_done", op), bus.busy, 0);
        check($sformatf("op%0d dout", op), bus.dout, r);
        check($sformatf("op%0d dout_hi", op), bus.dout_hi, hi);
        check($sformatf("op%0d flags", op), bus.flags_out & mask, fl & mask);
        check($sformatf("op%0d jmp", op), bus.jmp, jp);
        exp_dout = r; exp_hi = hi;
        @(posedge clk); #1;
        check($sformatf("op%0d done_width", op), bus.done, 0);
    endtask

    task automatic set_plan_regs();
        dr[0] = 8'h20; dr[1] = 8'h21; dr[2] = 8'h22; dr[3] = 8'h23;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, op;
        logic [NREG-1:0] t1, t2;
        bus.ealu = 1'b0; bus.start = 1'b0; bus.op = '0; bus.tgt1 = '0; bus.tgt2 = '0;
        bus.dr_flat = '0; bus.flags_in = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", bus.busy, 0);
        check("rst done", bus.done, 0);
        check("rst dout", bus.dout, 0);
        check("rst dout_hi", bus.dout_hi, 0);
        check("rst flags", bus.flags_out, 0);
        check("rst jmp", bus.jmp, 0);
        @(negedge clk);
        rst = 1'b0;

        set_plan_regs();
        run_op(0, 4'b0001, 4'b1000, 'h01, 0);
        check("plan add dout", bus.dout, 'h43);
        run_op(2, 4'b0001, 4'b1000, 'h01, 0);
        check("plan adc dout", bus.dout, 'h44);
        run_op(1, 4'b0001, 4'b1000, 'h01, 0);
        run_op(11, 4'b0001, 4'b0001, 'h01, 0);
        run_op(4, 4'b0001, 4'b1000, 'h01, 1);
        check("plan mul hi", bus.dout_hi, 'h04);
        run_op(5, 4'b1000, 4'b0001, 'h01, 0);
        dr[0] = 8'h00;
        run_op(5, 4'b1000, 4'b0001, 'h01, 0);
        check("plan div0 dz", bus.flags_out[4], 1);
        set_plan_regs();
        dr[3] = 8'h01;
        run_op(8, 4'b0001, 4'b1000, 'h01, 0);
        dr[3] = 8'h09;
        run_op(9, 4'b0001, 4'b1000, 'h01, 0);
        set_plan_regs();
        run_op(17, 4'b0001, 4'b1000, 'h01, 0);
        run_op(16, 4'b0001, 4'b1000, 'h01, 0);
        run_op(18, 4'b0001, 4'b1000, 'h01, 0);
        run_op(19, 4'b0001, 4'b1000, 'h02, 0);
        run_op(0, 4'b0000, 4'b0110, 'h00, 0);

        // Back-to-back: start held through the done cycle.
        set_plan_regs();
        @(negedge clk);
        load_dr();
        bus.op = 5'd0; bus.tgt1 = 4'b0001; bus.tgt2 = 4'b1000; bus.flags_in = 8'h01;
        bus.ealu = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        check("b2b first done", bus.done, 1);
        check("b2b first dout", bus.dout, 'h43);
        bus.op = 5'd12;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("b2b second done", bus.done, 1);
        check("b2b second dout", bus.dout, 'h20);
        exp_dout = 'h20; exp_hi = 0;
        @(posedge clk); #1;
        check("b2b done drops", bus.done, 0);

        // Start with ealu low is ignored.
        @(negedge clk);
        bus.ealu = 1'b0; bus.start = 1'b1; bus.op = 5'd0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1;
        end
        bus.start = 1'b0; bus.ealu = 1'b1;
        check("ealu off no done", seen, 0);
        check("ealu off dout held", bus.dout, exp_dout);

        // Reset four cycles into a MUL.
        @(negedge clk);
        bus.op = 5'd4; bus.tgt1 = 4'b0001; bus.tgt2 = 4'b1000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid mul busy", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst busy", bus.busy, 0);
        check("mid rst dout", bus.dout, 0);
        check("mid rst flags", bus.flags_out, 0);
        seen = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) seen = 1;
        end
        check("mid rst no done", seen, 0);
        exp_dout = 0; exp_hi = 0;
        run_op(0, 4'b0001, 4'b1000, 'h01, 0);

        for (int k = 0; k < 200; k++) begin
            for (int i = 0; i < NREG; i++)
                dr[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, W + 1)) : W'($urandom);
            op = ($urandom_range(0, 4) != 0) ? valid_ops[$urandom_range(0, 17)] : $urandom_range(0, 31);
            t1 = NREG'($urandom);
            t2 = NREG'($urandom);
            if (op == 4 && dr[sel(t2)] == '0) dr[sel(t2)] = W'(1);
            run_op(op, t1, t2, $urandom_range(0, 255), $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
